// File: rtl/rng_arbiter.sv
// rng_arbiter
// ---------------------------------------------------------------------------
// Controller and round-robin arbiter for the dual-LFSR random source.
// After every seed load it drives the rng block's reset for one cycle, lets
// WARMUP outputs go by, then hands the 64-bit word {rnd1, rnd2} to one
// requester per cycle. Because the rng advances every cycle and only one
// grant is issued per cycle, no word is ever delivered twice.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   seed_in    : seed captured when seed_load pulses (0 / all-ones replaced)
//   seed_load  : one-cycle reseed request, honoured in any state
//   req        : per-requester level request
//   gnt        : registered one-hot grant
//   rnd_out    : registered {rnd1, rnd2} delivered with gnt; holds otherwise
//   rnd_valid  : high while any gnt bit is high
//   ready      : high while arbitrating
//   draws      : words granted since the last seed load (wraps)
//   rng_seed   : to rng.seed
//   rng_reset  : to rng.reset (active-high)
//   rng_rnd1/2 : from rng.rnd1 / rng.rnd2
// ---------------------------------------------------------------------------
module rng_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          WARMUP       = 16,
  parameter logic [31:0] DEFAULT_SEED = 32'h1D87_2B41
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     seed_in,
  input  logic            seed_load,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [63:0]     rnd_out,
  output logic            rnd_valid,
  output logic            ready,
  output logic [15:0]     draws,
  output logic [31:0]     rng_seed,
  output logic            rng_reset,
  input  logic [31:0]     rng_rnd1,
  input  logic [31:0]     rng_rnd2
);

  localparam int            PW       = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [7:0]    WARM_LD  = 8'(WARMUP);

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [31:0]     seed_q;
  logic [7:0]      warm_cnt;
  logic [PW-1:0]   ptr;
  logic [15:0]     draws_q;

  logic [PW:0]     cand_p0;
  logic [PW-1:0]   win_idx_p0;
  logic            win_vld_p0;
  logic [PW-1:0]   ptr_nxt_p0;
  logic [NREQ-1:0] gnt_oh_p0;
  logic            grant_en_p0;

  logic [NREQ-1:0] gnt_p1;
  logic [63:0]     rnd_p1;
  logic            vld_p1;

  // All-zero or all-ones seeds would lock one of the two LFSRs (the second
  // one is loaded with ~seed), so both are swapped for the default.
  function automatic logic [31:0] legal_seed(input logic [31:0] s);
    if ((s == 32'h0000_0000) || (s == 32'hFFFF_FFFF)) begin
      return DEFAULT_SEED;
    end
    return s;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_SEED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a reseed overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEED: state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARM;
      ST_WARM: if (warm_cnt <= 8'd1) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_SEED;
    endcase
    if (seed_load) begin
      state_nxt = ST_SEED;
    end
  end

  // State-decoded outputs
  always_comb begin
    rng_reset = 1'b0;
    ready     = 1'b0;
    case (state)
      ST_SEED: rng_reset = 1'b1;
      ST_RUN:  ready     = 1'b1;
      default: ;
    endcase
  end

  // Seed register, warm-up counter, round-robin pointer and draw counter.
  // The pointer is deliberately kept across reseeds; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_q   <= DEFAULT_SEED;
      warm_cnt <= '0;
      ptr      <= '0;
      draws_q  <= '0;
    end else begin
      if (seed_load) begin
        seed_q <= legal_seed(seed_in);
      end

      if (state == ST_SEED) begin
        warm_cnt <= WARM_LD;
      end else if ((state == ST_WARM) && (warm_cnt != 8'd0)) begin
        warm_cnt <= warm_cnt - 8'd1;
      end

      if (grant_en_p0) begin
        ptr <= ptr_nxt_p0;
      end

      if (seed_load || (state == ST_SEED)) begin
        draws_q <= '0;
      end else if (grant_en_p0) begin
        draws_q <= draws_q + 16'd1;
      end
    end
  end

  // ---- stage p0: round-robin search starting at ptr ----
  always_comb begin
    win_vld_p0 = 1'b0;
    win_idx_p0 = '0;
    cand_p0    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // (ptr + k) mod NREQ without a divider: the sum is below 2*NREQ.
      cand_p0 = {1'b0, ptr} + (PW+1)'(k);
      if (cand_p0 >= NREQ_W) begin
        cand_p0 = cand_p0 - NREQ_W;
      end
      if (!win_vld_p0 && req[cand_p0[PW-1:0]]) begin
        win_vld_p0 = 1'b1;
        win_idx_p0 = cand_p0[PW-1:0];
      end
    end
  end

  always_comb begin
    ptr_nxt_p0 = (win_idx_p0 == LAST_IDX) ? '0 : (win_idx_p0 + PW'(1));
    gnt_oh_p0  = '0;
    gnt_oh_p0[win_idx_p0] = 1'b1;
  end

  // A reseed on the same edge suppresses the grant.
  assign grant_en_p0 = (state == ST_RUN) && !seed_load && win_vld_p0;

  // ---- stage p1: registered grant with the word it consumes ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_p1 <= '0;
      vld_p1 <= 1'b0;
      rnd_p1 <= '0;
    end else begin
      gnt_p1 <= grant_en_p0 ? gnt_oh_p0 : '0;
      vld_p1 <= grant_en_p0;
      if (grant_en_p0) begin
        rnd_p1 <= {rng_rnd1, rng_rnd2};
      end
    end
  end

  assign gnt       = gnt_p1;
  assign rnd_out   = rnd_p1;
  assign rnd_valid = vld_p1;
  assign draws     = draws_q;
  assign rng_seed  = seed_q;

endmodule

// File: tb/tb_rng_arbiter.sv
module tb_rng_arbiter;

  localparam int          NREQ   = 4;
  localparam int          WARM   = 16;
  localparam logic [31:0] DSEED  = 32'h1D87_2B41;
  localparam logic [31:0] SEED_S = 32'hCAFE_1234;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [31:0]     seed_in = '0;
  logic            seed_load = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic [63:0]     rnd_out;
  logic            rnd_valid;
  logic            ready;
  logic [15:0]     draws;
  logic [31:0]     rng_seed;
  logic            rng_reset;
  logic [31:0]     l1;
  logic [31:0]     l2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rng_arbiter #(
    .NREQ(NREQ), .WARMUP(WARM), .DEFAULT_SEED(DSEED)
  ) dut (
    .clk(clk), .reset(reset), .seed_in(seed_in), .seed_load(seed_load),
    .req(req), .gnt(gnt), .rnd_out(rnd_out), .rnd_valid(rnd_valid),
    .ready(ready), .draws(draws), .rng_seed(rng_seed), .rng_reset(rng_reset),
    .rng_rnd1(l1), .rng_rnd2(l2)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Stand-in for the rng block: two Galois LFSRs, loaded with seed / ~seed.
  always_ff @(posedge clk) begin
    if (rng_reset) begin
      l1 <= rng_seed;
      l2 <= ~rng_seed;
    end else begin
      l1 <= lfsr_step(l1);
      l2 <= lfsr_step(l2);
    end
  end

  // ---------------- reference model (timeline based) ----------------
  // m_age counts cycles since the seed cycle (0 = seed cycle).
  // Arbitration is live once m_age >= WARM + 1.
  int          m_age;
  logic [31:0] m_seed;
  logic [31:0] m_w1, m_w2;
  int          m_ptr;
  logic [3:0]  m_gnt;
  logic [63:0] m_rnd;
  logic [15:0] m_draws;

  function automatic logic [31:0] legal(input logic [31:0] s);
    return ((s == 32'h0) || (s == 32'hFFFF_FFFF)) ? DSEED : s;
  endfunction

  task automatic model_reset();
    m_age   = 0;
    m_seed  = DSEED;
    m_ptr   = 0;
    m_gnt   = '0;
    m_rnd   = '0;
    m_draws = '0;
  endtask

  task automatic model_step();
    int win;
    int idx;
    logic [3:0] g;
    g   = '0;
    win = -1;
    if ((m_age >= WARM + 1) && !seed_load) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if ((win < 0) && req[idx]) win = idx;
      end
    end
    if (win >= 0) begin
      g[win]  = 1'b1;
      m_rnd   = {m_w1, m_w2};
      m_draws = m_draws + 16'd1;
      m_ptr   = (win + 1) % NREQ;
    end
    m_gnt = g;
    if (m_age == 0) begin
      m_w1 = m_seed;
      m_w2 = ~m_seed;
    end else begin
      m_w1 = lfsr_step(m_w1);
      m_w2 = lfsr_step(m_w2);
    end
    if (seed_load) begin
      m_seed  = legal(seed_in);
      m_age   = 0;
      m_draws = '0;
    end else if (m_age < 1000000) begin
      m_age = m_age + 1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt"},       64'(gnt),       64'(m_gnt));
    chk({tag, ".rnd_out"},   rnd_out,        m_rnd);
    chk({tag, ".rnd_valid"}, 64'(rnd_valid), 64'(|m_gnt));
    chk({tag, ".ready"},     64'(ready),     64'(m_age >= WARM + 1));
    chk({tag, ".draws"},     64'(draws),     64'(m_draws));
    chk({tag, ".rng_seed"},  64'(rng_seed),  64'(m_seed));
    chk({tag, ".rng_reset"}, 64'(rng_reset), 64'(m_age == 0));
  endtask

  task automatic cycle(input logic [NREQ-1:0] r, input logic sl, input logic [31:0] si);
    req       = r;
    seed_load = sl;
    seed_in   = si;
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    @(negedge clk);
    check_all("model");
  endtask

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [15:0] draws;
  } vec_t;

  vec_t        tbl [0:14];
  logic [63:0] words [0:7];
  logic [63:0] run_a [0:5];
  logic [63:0] run_b [0:5];
  logic        dup;
  logic [31:0] rv;
  logic [31:0] rs;
  logic        rl;

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001, 16'd1};
    tbl[1]  = '{4'b1111, 4'b0010, 16'd2};
    tbl[2]  = '{4'b1111, 4'b0100, 16'd3};
    tbl[3]  = '{4'b1111, 4'b1000, 16'd4};
    tbl[4]  = '{4'b1111, 4'b0001, 16'd5};
    tbl[5]  = '{4'b1111, 4'b0010, 16'd6};
    tbl[6]  = '{4'b1111, 4'b0100, 16'd7};
    tbl[7]  = '{4'b1111, 4'b1000, 16'd8};
    tbl[8]  = '{4'b1010, 4'b0010, 16'd9};
    tbl[9]  = '{4'b1010, 4'b1000, 16'd10};
    tbl[10] = '{4'b1010, 4'b0010, 16'd11};
    tbl[11] = '{4'b0100, 4'b0100, 16'd12};
    tbl[12] = '{4'b0100, 4'b0100, 16'd13};
    tbl[13] = '{4'b0100, 4'b0100, 16'd14};
    tbl[14] = '{4'b0000, 4'b0000, 16'd14};

    // Reset held: reset values
    model_reset();
    repeat (3) cycle('0, 1'b0, '0);
    chk("rst.gnt",       64'(gnt),       64'h0);
    chk("rst.rnd_out",   rnd_out,        64'h0);
    chk("rst.ready",     64'(ready),     64'h0);
    chk("rst.draws",     64'(draws),     64'h0);
    chk("rst.rng_seed",  64'(rng_seed),  64'(DSEED));
    chk("rst.rng_reset", 64'(rng_reset), 64'h1);

    // Release: one seed cycle, ready rises 17 cycles later
    reset = 1'b1;
    #1;
    chk("auto.seed_cycle", 64'(rng_reset), 64'h1);
    for (int i = 1; i <= WARM + 1; i++) begin
      cycle('0, 1'b0, '0);
      chk($sformatf("auto.ready%0d", i), 64'(ready), 64'(i == WARM + 1));
      chk($sformatf("auto.rng_reset%0d", i), 64'(rng_reset), 64'h0);
    end

    // Round robin and sparse request table
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].req, 1'b0, '0);
      chk($sformatf("tbl%0d.gnt", i),   64'(gnt),   64'(tbl[i].gnt));
      chk($sformatf("tbl%0d.draws", i), 64'(draws), 64'(tbl[i].draws));
      if (i < 8) words[i] = rnd_out;
    end
    dup = 1'b0;
    for (int a = 0; a < 8; a++)
      for (int b = a + 1; b < 8; b++)
        if (words[a] == words[b]) dup = 1'b1;
    chk("rr.distinct", 64'(dup), 64'h0);

    // Illegal and legal seeds
    cycle('0, 1'b1, 32'hFFFF_FFFF);
    chk("ill_ones.seed",  64'(rng_seed),  64'(DSEED));
    chk("ill_ones.reset", 64'(rng_reset), 64'h1);
    cycle('0, 1'b1, 32'h0000_0000);
    chk("ill_zero.seed",  64'(rng_seed),  64'(DSEED));
    cycle('0, 1'b1, 32'h0000_0001);
    chk("legal_one.seed", 64'(rng_seed),  64'h1);
    for (int i = 0; i <= WARM; i++) cycle('0, 1'b0, '0);

    // Reseed mid-RUN, twice with the same seed
    for (int i = 0; i < 3; i++) cycle(4'b0001, 1'b0, '0);
    chk("pre_reseed.gnt", 64'(gnt), 64'h1);
    for (int p = 0; p < 2; p++) begin
      cycle(4'b0001, 1'b1, SEED_S);
      chk($sformatf("reseed%0d.gnt", p),   64'(gnt),      64'h0);
      chk($sformatf("reseed%0d.draws", p), 64'(draws),    64'h0);
      chk($sformatf("reseed%0d.ready", p), 64'(ready),    64'h0);
      chk($sformatf("reseed%0d.seed", p),  64'(rng_seed), 64'(SEED_S));
      for (int i = 1; i <= WARM + 2; i++) begin
        cycle(4'b0001, 1'b0, '0);
        chk($sformatf("resume%0d.%0d", p, i), 64'(gnt), (i == WARM + 2) ? 64'h1 : 64'h0);
      end
      if (p == 0) run_a[0] = rnd_out;
      else        run_b[0] = rnd_out;
      for (int i = 1; i < 6; i++) begin
        cycle(4'b0001, 1'b0, '0);
        if (p == 0) run_a[i] = rnd_out;
        else        run_b[i] = rnd_out;
      end
    end
    for (int i = 0; i < 6; i++) chk($sformatf("restart%0d", i), run_b[i], run_a[i]);

    // Async reset between edges while granting
    cycle(4'b0100, 1'b0, '0);
    cycle(4'b0100, 1'b0, '0);
    chk("arst.pre_gnt", 64'(gnt), 64'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.gnt",       64'(gnt),       64'h0);
    chk("arst.rnd_valid", 64'(rnd_valid), 64'h0);
    chk("arst.ready",     64'(ready),     64'h0);
    chk("arst.rng_reset", 64'(rng_reset), 64'h1);
    model_reset();
    cycle(4'b0100, 1'b0, '0);
    cycle(4'b0100, 1'b0, '0);
    reset = 1'b1;
    for (int i = 0; i <= WARM + 1; i++) cycle('0, 1'b0, '0);

    // Randomized traffic with occasional (sometimes illegal) reseeds
    for (int n = 0; n < 800; n++) begin
      rv = $urandom;
      rl = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 5))
        0:       rs = 32'h0000_0000;
        1:       rs = 32'hFFFF_FFFF;
        default: rs = $urandom;
      endcase
      cycle(rv[NREQ-1:0], rl, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
